// File: rtl/writeback_stage.sv
// Writeback stage: registers ALU results and load data into the register-file write port.
// States: IDLE (accept EX/MEM instruction) | WAIT_LOAD (hold captured load until ack or timeout).
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic        clock__i,
  input  logic        rst_n__i,
  input  logic        Valid__i,
  input  logic        RegWrite__i,
  input  logic        MemRead__i,
  input  logic [2:0]  LoadType__i,
  input  logic [4:0]  AddrRd__i,
  input  logic [31:0] AluResult__i,
  input  logic [31:0] DmemRdata__i,
  input  logic        DmemAck__i,
  output logic        Stall__o,
  output logic        RegWrite__o,
  output logic [4:0]  AddrRd__o,
  output logic [31:0] DataRd__o,
  output logic        LoadErr__o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cap_wr_q, cap_wr_d;
  logic [2:0]  cap_type_q, cap_type_d;
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic [1:0]  cap_off_q, cap_off_d;
  logic        wr_q, wr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        ld_wr;
  logic [2:0]  ld_type;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_off;

  function automatic logic ld_is_err(input logic [2:0] t, input logic [1:0] off);
    case (t)
      3'b000, 3'b100: ld_is_err = 1'b0;
      3'b001, 3'b101: ld_is_err = off[0];
      3'b011:         ld_is_err = (off != 2'b00);
      default:        ld_is_err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_extract(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  ld_extract = {{24{b[7]}}, b};
      3'b100:  ld_extract = {24'd0, b};
      3'b001:  ld_extract = {{16{h[15]}}, h};
      3'b101:  ld_extract = {16'd0, h};
      default: ld_extract = w;
    endcase
  endfunction

  always_ff @(posedge clock__i or negedge rst_n__i) begin
    if (!rst_n__i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_wr_q   <= 1'b0;
      cap_type_q <= '0;
      cap_rd_q   <= '0;
      cap_off_q  <= '0;
      wr_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_wr_q   <= cap_wr_d;
      cap_type_q <= cap_type_d;
      cap_rd_q   <= cap_rd_d;
      cap_off_q  <= cap_off_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // In WAIT_LOAD the retiring load comes only from the captured copies.
  always_comb begin
    ld_wr   = (state_q == S_WAIT) ? cap_wr_q   : RegWrite__i;
    ld_type = (state_q == S_WAIT) ? cap_type_q : LoadType__i;
    ld_rd   = (state_q == S_WAIT) ? cap_rd_q   : AddrRd__i;
    ld_off  = (state_q == S_WAIT) ? cap_off_q  : AluResult__i[1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_wr_d   = cap_wr_q;
    cap_type_d = cap_type_q;
    cap_rd_d   = cap_rd_q;
    cap_off_d  = cap_off_q;
    wr_d       = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (Valid__i && !MemRead__i) begin
          wr_d   = RegWrite__i && (AddrRd__i != 5'd0);
          rd_d   = AddrRd__i;
          data_d = AluResult__i;
        end else if (Valid__i && !DmemAck__i) begin
          cap_wr_d   = RegWrite__i;
          cap_type_d = LoadType__i;
          cap_rd_d   = AddrRd__i;
          cap_off_d  = AluResult__i[1:0];
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DmemAck__i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Load retire shared by the immediate-ack and late-ack paths.
    if (DmemAck__i && ((state_q == S_WAIT) || (Valid__i && MemRead__i))) begin
      if (ld_is_err(ld_type, ld_off)) begin
        err_d = 1'b1;
      end else begin
        wr_d   = ld_wr && (ld_rd != 5'd0);
        rd_d   = ld_rd;
        data_d = ld_extract(ld_type, ld_off, DmemRdata__i);
      end
    end
  end

  always_comb begin
    Stall__o = 1'b0;
    case (state_q)
      S_IDLE:  Stall__o = Valid__i && MemRead__i && !DmemAck__i;
      S_WAIT:  Stall__o = !DmemAck__i;
      default: Stall__o = 1'b0;
    endcase
  end

  assign RegWrite__o = wr_q;
  assign AddrRd__o   = rd_q;
  assign DataRd__o   = data_q;
  assign LoadErr__o  = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: random traffic against a behavioural model, plus literal directed checks.
module tb_writeback_stage;
  localparam int unsigned TO = 15;

  logic        clk, rst_n;
  logic        valid, rw, mr, ack;
  logic [2:0]  lt;
  logic [4:0]  rd;
  logic [31:0] alu, rdata;
  logic        stall, wr_o, err_o;
  logic [4:0]  rd_o;
  logic [31:0] data_o;

  int n_cmp = 0;
  int n_mis = 0;

  writeback_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clock__i(clk), .rst_n__i(rst_n), .Valid__i(valid), .RegWrite__i(rw),
    .MemRead__i(mr), .LoadType__i(lt), .AddrRd__i(rd), .AluResult__i(alu),
    .DmemRdata__i(rdata), .DmemAck__i(ack), .Stall__o(stall), .RegWrite__o(wr_o),
    .AddrRd__o(rd_o), .DataRd__o(data_o), .LoadErr__o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend;
  bit          m_pwr;
  bit [2:0]    m_ptype;
  bit [4:0]    m_prd;
  bit [1:0]    m_poff;
  int          m_waited;
  bit          m_wr, m_err;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;

  function automatic bit bad_load(input bit [2:0] t, input bit [1:0] off);
    int size;
    if (!(t inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5})) return 1'b1;
    size = (t == 3'd3) ? 4 : ((t == 3'd1 || t == 3'd5) ? 2 : 1);
    return (int'(off) % size) != 0;
  endfunction

  function automatic bit [31:0] load_value(input bit [2:0] t, input bit [1:0] off, input bit [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic m_reset();
    m_pend = 0; m_waited = 0; m_wr = 0; m_err = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic m_retire(input bit w, input bit [2:0] t, input bit [4:0] r,
                          input bit [1:0] off, input bit [31:0] word);
    if (bad_load(t, off)) m_err = 1;
    else begin
      m_wr = w && (r != 0);
      m_rd = r;
      m_data = load_value(t, off, word);
    end
  endtask

  task automatic m_step();
    m_wr = 0;
    if (m_pend) begin
      if (ack) begin
        m_retire(m_pwr, m_ptype, m_prd, m_poff, rdata);
        m_pend = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_err = 1;
          m_pend = 0;
        end
      end
    end else if (valid && !mr) begin
      m_wr = rw && (rd != 0);
      m_rd = rd;
      m_data = alu;
    end else if (valid && ack) begin
      m_retire(rw, lt, rd, alu[1:0], rdata);
    end else if (valid) begin
      m_pend = 1; m_pwr = rw; m_ptype = lt; m_prd = rd; m_poff = alu[1:0]; m_waited = 0;
    end
  endtask

  initial m_reset();

  // Inputs change shortly after each rising edge, so the falling edge sees them settled.
  always @(negedge clk) begin
    bit exp_stall;
    if (!rst_n) m_reset();
    exp_stall = m_pend ? !ack : (valid && mr && !ack);
    chk("model.stall", 32'(stall), 32'(exp_stall));
    chk("model.regwrite", 32'(wr_o), 32'(m_wr));
    chk("model.addrrd", 32'(rd_o), 32'(m_rd));
    chk("model.datard", data_o, m_data);
    chk("model.loaderr", 32'(err_o), 32'(m_err));
    if (rst_n) m_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    valid = 0; rw = 0; mr = 0; lt = 0; rd = 0; alu = 0; rdata = 0; ack = 0;
  endtask

  task automatic set_alu(input bit w, input bit [4:0] r, input bit [31:0] a);
    idle_in();
    valid = 1; rw = w; rd = r; alu = a;
  endtask

  task automatic set_ld(input bit [2:0] t, input bit [4:0] r, input bit [31:0] a,
                        input bit [31:0] d, input bit k);
    idle_in();
    valid = 1; rw = 1; mr = 1; lt = t; rd = r; alu = a; rdata = d; ack = k;
  endtask

  initial begin
    int ack_pct;
    idle_in();
    rst_n = 0;
    tick(); tick();
    chk("reset.regwrite", 32'(wr_o), 0);
    chk("reset.datard", data_o, 0);
    chk("reset.stall", 32'(stall), 0);
    rst_n = 1;
    tick();

    set_alu(1, 5'd5, 32'h1234_5678);
    #1 chk("alu.stall", 32'(stall), 0);
    tick();
    chk("alu.regwrite", 32'(wr_o), 1);
    chk("alu.addrrd", 32'(rd_o), 5);
    chk("alu.datard", data_o, 32'h1234_5678);

    set_ld(3'b000, 5'd7, 32'h0000_1003, 32'h80FF_7F01, 1);
    tick();
    chk("lb.datard", data_o, 32'hFFFF_FF80);
    chk("lb.regwrite", 32'(wr_o), 1);
    set_ld(3'b100, 5'd7, 32'h0000_1003, 32'h80FF_7F01, 1);
    tick();
    chk("lbu.datard", data_o, 32'h0000_0080);
    set_ld(3'b001, 5'd8, 32'h0000_1002, 32'h80FF_7F01, 1);
    tick();
    chk("lh.datard", data_o, 32'hFFFF_80FF);
    idle_in();
    tick();
    chk("bubble.regwrite", 32'(wr_o), 0);
    chk("bubble.hold", data_o, 32'hFFFF_80FF);

    // delayed LW: three stalled cycles, then retire
    set_ld(3'b011, 5'd9, 32'h0000_0100, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("delay.stall", 32'(stall), 1);
      tick();
      chk("delay.nowrite", 32'(wr_o), 0);
      set_alu(1, 5'd3, 32'hDEAD_0000);
    end
    ack = 1; rdata = 32'hCAFE_BABE;
    #1 chk("delay.stall_drop", 32'(stall), 0);
    tick();
    chk("delay.regwrite", 32'(wr_o), 1);
    chk("delay.addrrd", 32'(rd_o), 9);
    chk("delay.datard", data_o, 32'hCAFE_BABE);
    idle_in();
    tick();
    chk("delay.onepulse", 32'(wr_o), 0);

    // ack on the last allowed WAIT cycle wins over timeout
    set_ld(3'b011, 5'd10, 32'h0000_0200, 32'h0, 0);
    tick();
    idle_in();
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    #1 chk("ack15.stall", 32'(stall), 1);
    ack = 1; rdata = 32'h0BAD_F00D;
    tick();
    chk("ack15.regwrite", 32'(wr_o), 1);
    chk("ack15.datard", data_o, 32'h0BAD_F00D);
    chk("ack15.loaderr", 32'(err_o), 0);

    // timeout: no ack ever
    set_ld(3'b011, 5'd11, 32'h0000_0300, 32'h0, 0);
    tick();
    idle_in();
    for (int i = 0; i < int'(TO); i++) begin
      #1 chk("timeout.stall", 32'(stall), 1);
      tick();
    end
    #1 chk("timeout.stall_drop", 32'(stall), 0);
    chk("timeout.nowrite", 32'(wr_o), 0);
    chk("timeout.loaderr", 32'(err_o), 1);
    tick(); tick();
    chk("timeout.sticky", 32'(err_o), 1);

    set_alu(1, 5'd0, 32'h5555_AAAA);
    tick();
    chk("rd0.regwrite", 32'(wr_o), 0);

    rst_n = 0; idle_in();
    tick();
    rst_n = 1;
    chk("rst.loaderr_clear", 32'(err_o), 0);
    set_ld(3'b001, 5'd12, 32'h0000_0401, 32'h1111_2222, 1);
    tick();
    chk("lhmis.regwrite", 32'(wr_o), 0);
    chk("lhmis.loaderr", 32'(err_o), 1);

    // reset while a load is pending, then a stale ack
    rst_n = 0; idle_in();
    tick();
    rst_n = 1;
    set_ld(3'b011, 5'd13, 32'h0000_0500, 32'h0, 0);
    tick();
    idle_in();
    tick();
    rst_n = 0;
    tick();
    chk("rstwait.regwrite", 32'(wr_o), 0);
    chk("rstwait.datard", data_o, 0);
    chk("rstwait.loaderr", 32'(err_o), 0);
    rst_n = 1; ack = 1; rdata = 32'h7777_7777;
    #1 chk("rstwait.stall", 32'(stall), 0);
    tick();
    chk("rstwait.nowrite", 32'(wr_o), 0);
    chk("rstwait.addrrd", 32'(rd_o), 0);
    chk("rstwait.datard2", data_o, 0);

    // randomized traffic
    ack_pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 3 : 40;
      valid = ($urandom_range(0, 3) != 0);
      mr    = $urandom_range(0, 1);
      rw    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1:    lt = 3'd0;
        2, 3:    lt = 3'd1;
        4, 5:    lt = 3'd3;
        6:       lt = 3'd4;
        7, 8:    lt = 3'd5;
        default: lt = 3'($urandom);
      endcase
      rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu   = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      rdata = $urandom;
      ack   = ($urandom_range(0, 99) < ack_pct);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    rst_n = 1; idle_in();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
